// File: rtl/pmp_pkg.sv
// Shared definitions for the PMP CSR writer: A-field encodings, CSR bases,
// write-engine states and a low-bit mask helper.
package pmp_pkg;

  localparam logic [1:0]  A_OFF        = 2'd0;
  localparam logic [1:0]  A_TOR        = 2'd1;
  localparam logic [1:0]  A_NA4        = 2'd2;
  localparam logic [1:0]  A_NAPOT      = 2'd3;

  localparam logic [11:0] PMPCFG_BASE  = 12'h3A0;
  localparam logic [11:0] PMPADDR_BASE = 12'h3B0;
  localparam logic [11:0] PMPADDR_LAST = 12'h3EF;

  localparam logic [7:0]  CFG_WMASK    = 8'h9F;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_CFG  = 1'b1
  } pmp_state_e;

  // Returns a 64-bit value with bits [n-1:0] set; n <= 0 yields zero.
  function automatic logic [63:0] low_mask(input int n);
    logic [63:0] m;
    m = 64'd0;
    for (int b = 0; b < 64; b++) begin
      if (b < n) m[b] = 1'b1;
      else       m[b] = 1'b0;
    end
    return m;
  endfunction

endpackage

// File: rtl/pmp_cfg_legalize.sv
// WARL legalization of one pmpcfg byte: clears the reserved bits, drops the
// reserved W-without-R combination and folds NA4 to OFF on coarse granularity.
module pmp_cfg_legalize
  import pmp_pkg::*;
#(
  parameter int PMP_G = 0
) (
  input  logic [7:0] i_new_byte,
  input  logic [7:0] i_old_byte,
  output logic [7:0] o_byte
);

  logic [7:0] w_masked;
  logic [1:0] w_a;

  assign w_masked = i_new_byte & CFG_WMASK;
  assign w_a      = ((PMP_G >= 1) && (w_masked[4:3] == A_NA4)) ? A_OFF : w_masked[4:3];

  // W=1 with R=0 is reserved, so such a write leaves the entry untouched
  assign o_byte = (i_new_byte[1:0] == 2'b10) ? i_old_byte
                                             : {w_masked[7:5], w_a, w_masked[2:0]};

endmodule

// File: rtl/pmp_csr_writer.sv
// PMP register file and CSR write engine: holds pmpcfg/pmpaddr state, applies
// lock and WARL rules, commits pmpcfg writes one byte per cycle.
module pmp_csr_writer
  import pmp_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int PA_BITS     = 56,
  parameter int PMP_ENTRIES = 16,
  parameter int PMP_G       = 0
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        CSRWValid,
  output logic                        CSRWReady,
  input  logic [11:0]                 CSRWAdr,
  input  logic [XLEN-1:0]             CSRWData,
  input  logic [11:0]                 CSRRAdr,
  output logic [XLEN-1:0]             CSRRData,
  output logic                        IllegalAccess,
  output logic                        PMPUpdated,
  output logic [8*PMP_ENTRIES-1:0]    PMPCfgArray,
  output logic [XLEN*PMP_ENTRIES-1:0] PMPAdrArray
);

  localparam int              NBYTES     = XLEN / 8;
  localparam int              KW         = $clog2(NBYTES);
  localparam logic [KW-1:0]   K_LAST     = KW'(NBYTES - 1);
  localparam logic [6:0]      N_ENT      = 7'(PMP_ENTRIES);
  localparam logic [XLEN-1:0] ADDR_WMASK = XLEN'(low_mask(PA_BITS - 2));
  localparam logic [XLEN-1:0] NAPOT_ONES = XLEN'(low_mask(PMP_G - 1));
  localparam logic [XLEN-1:0] GRAN_MASK  = XLEN'(low_mask(PMP_G));

  pmp_state_e      r_state;
  logic [KW-1:0]   r_k;
  logic [XLEN-1:0] r_data;
  logic [5:0]      r_base;
  logic [7:0]      r_cfg  [PMP_ENTRIES];
  logic [XLEN-1:0] r_addr [PMP_ENTRIES];
  logic            r_illegal;
  logic            r_updated;

  logic [7:0]      w_cfg_tab  [0:64];
  logic [XLEN-1:0] w_addr_tab [0:63];

  logic            w_wr_cfg;
  logic            w_wr_addr;
  logic            w_cfg_odd;
  logic [5:0]      w_wr_n;
  logic [6:0]      w_wr_n7;
  logic [6:0]      w_wr_nxt;
  logic            w_addr_locked;

  logic [6:0]      w_idx;
  logic [7:0]      w_new_byte;
  logic [7:0]      w_old_byte;
  logic [7:0]      w_legal_byte;
  logic            w_cfg_we;

  logic [6:0]      w_rd_base;
  logic [5:0]      w_rd_n;
  logic [XLEN-1:0] w_rdata;

  // Zero-padded 64-entry views so decode never indexes past the implemented entries
  always_comb begin
    for (int e = 0; e < 65; e++) w_cfg_tab[e] = 8'h00;
    for (int e = 0; e < 64; e++) w_addr_tab[e] = '0;
    for (int e = 0; e < PMP_ENTRIES; e++) begin
      w_cfg_tab[e]  = r_cfg[e];
      w_addr_tab[e] = r_addr[e];
    end
  end

  assign w_wr_cfg  = (CSRWAdr[11:4] == PMPCFG_BASE[11:4]);
  assign w_wr_addr = (CSRWAdr >= PMPADDR_BASE) && (CSRWAdr <= PMPADDR_LAST);
  assign w_cfg_odd = (XLEN == 64) && CSRWAdr[0];
  assign w_wr_n    = CSRWAdr[5:0] - PMPADDR_BASE[5:0];
  assign w_wr_n7   = {1'b0, w_wr_n};
  assign w_wr_nxt  = w_wr_n7 + 7'd1;

  // A TOR entry above also owns this address register as its lower bound
  assign w_addr_locked = (w_wr_n7 >= N_ENT) || w_cfg_tab[w_wr_n7][7] ||
                         (w_cfg_tab[w_wr_nxt][7] && (w_cfg_tab[w_wr_nxt][4:3] == A_TOR));

  assign w_idx      = {1'b0, r_base} + 7'(r_k);
  assign w_new_byte = r_data[{r_k, 3'b000} +: 8];
  assign w_old_byte = w_cfg_tab[w_idx];
  assign w_cfg_we   = (r_state == ST_CFG) && (w_idx < N_ENT) && !w_old_byte[7];

  pmp_cfg_legalize #(
    .PMP_G      (PMP_G)
  ) u_legalize (
    .i_new_byte (w_new_byte),
    .i_old_byte (w_old_byte),
    .o_byte     (w_legal_byte)
  );

  // Write engine: address writes commit at once, cfg writes walk one byte per cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_k       <= '0;
      r_data    <= '0;
      r_base    <= 6'd0;
      r_illegal <= 1'b0;
      r_updated <= 1'b0;
      for (int e = 0; e < PMP_ENTRIES; e++) begin
        r_cfg[e]  <= 8'h00;
        r_addr[e] <= '0;
      end
    end else begin
      r_illegal <= 1'b0;
      r_updated <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (CSRWValid && w_wr_addr) begin
            r_updated <= 1'b1;
            for (int e = 0; e < PMP_ENTRIES; e++) begin
              if (!w_addr_locked && (w_wr_n == 6'(e))) r_addr[e] <= CSRWData & ADDR_WMASK;
            end
          end else if (CSRWValid && w_wr_cfg && w_cfg_odd) begin
            r_illegal <= 1'b1;
          end else if (CSRWValid && w_wr_cfg) begin
            r_data  <= CSRWData;
            r_base  <= {CSRWAdr[3:0], 2'b00};
            r_k     <= '0;
            r_state <= ST_CFG;
          end
        end
        ST_CFG: begin
          for (int e = 0; e < PMP_ENTRIES; e++) begin
            if (w_cfg_we && (w_idx == 7'(e))) r_cfg[e] <= w_legal_byte;
          end
          r_k <= r_k + KW'(1);
          if (r_k == K_LAST) begin
            r_state   <= ST_IDLE;
            r_updated <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign CSRWReady     = (r_state == ST_IDLE);
  assign IllegalAccess = r_illegal;
  assign PMPUpdated    = r_updated;

  // Packed views for the per-entry address decoders
  always_comb begin
    PMPCfgArray = '0;
    PMPAdrArray = '0;
    for (int e = 0; e < PMP_ENTRIES; e++) begin
      PMPCfgArray[8*e +: 8]       = r_cfg[e];
      PMPAdrArray[XLEN*e +: XLEN] = r_addr[e];
    end
  end

  // CSR read mux; pmpaddr low bits reflect the granularity of the entry's mode
  always_comb begin
    w_rdata   = '0;
    w_rd_base = {1'b0, CSRRAdr[3:0], 2'b00};
    w_rd_n    = CSRRAdr[5:0] - PMPADDR_BASE[5:0];
    if (CSRRAdr[11:4] == PMPCFG_BASE[11:4]) begin
      if ((XLEN == 64) && CSRRAdr[0]) begin
        w_rdata = '0;
      end else begin
        for (int b = 0; b < NBYTES; b++) w_rdata[8*b +: 8] = w_cfg_tab[w_rd_base + 7'(b)];
      end
    end else if ((CSRRAdr >= PMPADDR_BASE) && (CSRRAdr <= PMPADDR_LAST)) begin
      w_rdata = w_addr_tab[w_rd_n];
      if (w_cfg_tab[{1'b0, w_rd_n}][4:3] == A_NAPOT) w_rdata = w_rdata | NAPOT_ONES;
      else                                           w_rdata = w_rdata & ~GRAN_MASK;
    end else begin
      w_rdata = '0;
    end
  end

  assign CSRRData = w_rdata;

endmodule

// File: tb/tb_pmp_csr_writer.sv
// Self-checking bench for pmp_csr_writer: directed vector table, randomized
// writes against a behavioural model, and hand-written reset/back-to-back sequences.
module tb_pmp_csr_writer;

  localparam int XL = 64;
  localparam int PA = 40;
  localparam int NE = 12;
  localparam int G  = 2;

  logic            clk       = 1'b0;
  logic            reset_n   = 1'b0;
  logic            CSRWValid = 1'b0;
  logic [11:0]     CSRWAdr   = 12'h000;
  logic [XL-1:0]   CSRWData  = 64'd0;
  logic [11:0]     CSRRAdr   = 12'h000;
  logic            CSRWReady;
  logic [XL-1:0]   CSRRData;
  logic            IllegalAccess;
  logic            PMPUpdated;
  logic [8*NE-1:0] PMPCfgArray;
  logic [XL*NE-1:0] PMPAdrArray;

  pmp_csr_writer #(
    .XLEN(XL), .PA_BITS(PA), .PMP_ENTRIES(NE), .PMP_G(G)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .CSRWValid(CSRWValid), .CSRWReady(CSRWReady),
    .CSRWAdr(CSRWAdr), .CSRWData(CSRWData),
    .CSRRAdr(CSRRAdr), .CSRRData(CSRRData),
    .IllegalAccess(IllegalAccess), .PMPUpdated(PMPUpdated),
    .PMPCfgArray(PMPCfgArray), .PMPAdrArray(PMPAdrArray)
  );

  always #5 clk = ~clk;

  int n_pass   = 0;
  int n_checks = 0;

  logic [7:0]  m_cfg  [0:63];
  logic [63:0] m_addr [0:63];

  typedef struct {
    logic [11:0] wadr;
    logic [63:0] wdata;
    logic [11:0] radr;
    logic [63:0] rexp;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) begin
      m_cfg[i]  = 8'h00;
      m_addr[i] = 64'd0;
    end
  endfunction

  // 0 = other CSR, 1 = pmpaddr, 2 = legal pmpcfg, 3 = odd pmpcfg
  function automatic int kind_of(input logic [11:0] adr);
    if (adr >= 12'h3B0 && adr <= 12'h3EF) return 1;
    if (adr >= 12'h3A0 && adr <= 12'h3AF) return adr[0] ? 3 : 2;
    return 0;
  endfunction

  function automatic void model_write(input logic [11:0] adr, input logic [63:0] data);
    int n;
    int i;
    logic [7:0] nb;
    if (kind_of(adr) == 1) begin
      n = int'(adr) - 'h3B0;
      if (n < NE && m_cfg[n][7] == 1'b0 &&
          !(n + 1 < NE && m_cfg[n+1][7] == 1'b1 && m_cfg[n+1][4:3] == 2'd1))
        m_addr[n] = data & ((64'd1 << (PA - 2)) - 64'd1);
    end else if (kind_of(adr) == 2) begin
      for (int b = 0; b < 8; b++) begin
        i  = 4 * int'(adr[3:0]) + b;
        nb = data[8*b +: 8];
        if (i < NE && m_cfg[i][7] == 1'b0) begin
          if (nb[1:0] != 2'b10) begin
            nb = nb & 8'h9F;
            if (nb[4:3] == 2'd2) nb[4:3] = 2'd0;
            m_cfg[i] = nb;
          end
        end
      end
    end
  endfunction

  function automatic logic [63:0] model_read(input logic [11:0] adr);
    logic [63:0] v;
    int n;
    int i;
    v = 64'd0;
    if (kind_of(adr) == 2) begin
      for (int b = 0; b < 8; b++) begin
        i = 4 * int'(adr[3:0]) + b;
        if (i < NE) v[8*b +: 8] = m_cfg[i];
      end
    end else if (kind_of(adr) == 1) begin
      n = int'(adr) - 'h3B0;
      if (n < NE) begin
        v = m_addr[n];
        if (m_cfg[n][4:3] == 2'd3) v = v | ((64'd1 << (G - 1)) - 64'd1);
        else                       v = v & ~((64'd1 << G) - 64'd1);
      end
    end
    return v;
  endfunction

  function automatic logic [63:0] rand_data();
    logic [63:0] d;
    d = {$urandom, $urandom};
    for (int b = 0; b < 8; b++) if ($urandom_range(0, 15) != 0) d[8*b+7] = 1'b0;
    return d;
  endfunction

  task automatic check_arrays(input string tag);
    for (int e = 0; e < NE; e++) begin
      check({tag, "_cfgarr"}, 64'(PMPCfgArray[8*e +: 8]), 64'(m_cfg[e]));
      check({tag, "_adrarr"}, PMPAdrArray[XL*e +: XL], m_addr[e]);
    end
  endtask

  // Issue one write from a negedge and watch 12 cycles of handshake/pulse activity.
  task automatic do_write(input logic [11:0] adr, input logic [63:0] data);
    int ready_low;
    int upd_n;
    int ill_n;
    int first_upd;
    int waitc;
    int k;
    ready_low = 0; upd_n = 0; ill_n = 0; first_upd = 0; waitc = 0;
    while (CSRWReady !== 1'b1 && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    check("ready_before_write", 64'(CSRWReady), 64'd1);
    CSRWAdr   = adr;
    CSRWData  = data;
    CSRWValid = 1'b1;
    @(posedge clk);
    model_write(adr, data);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      CSRWValid = 1'b0;
      if (CSRWReady !== 1'b1) ready_low++;
      if (PMPUpdated === 1'b1) begin
        upd_n++;
        if (first_upd == 0) first_upd = c;
      end
      if (IllegalAccess === 1'b1) ill_n++;
    end
    k = kind_of(adr);
    check("ready_low_cycles", 64'(ready_low), (k == 2) ? 64'd8 : 64'd0);
    check("updated_pulses", 64'(upd_n), (k == 1 || k == 2) ? 64'd1 : 64'd0);
    check("illegal_pulses", 64'(ill_n), (k == 3) ? 64'd1 : 64'd0);
    if (k == 1 || k == 2)
      check("updated_cycle", 64'(first_upd), (k == 2) ? 64'd9 : 64'd1);
  endtask

  initial begin
    vec_t vecs [22];
    logic [11:0] a;
    int upd_n;

    vecs[0]  = '{12'h3A0, 64'h0000_0000_0000_1F0F, 12'h3A0, 64'h0000_0000_0000_1F0F};
    vecs[1]  = '{12'h3A0, 64'h0000_0000_0000_0001, 12'h3A0, 64'h0000_0000_0000_0001};
    vecs[2]  = '{12'h3A0, 64'h0000_0000_0000_6F02, 12'h3A0, 64'h0000_0000_0000_0F01};
    vecs[3]  = '{12'h3A0, 64'h0000_0000_0000_0011, 12'h3A0, 64'h0000_0000_0000_0001};
    vecs[4]  = '{12'h3B0, 64'hFFFF_FFFF_FFFF_FFFF, 12'h3B0, 64'h0000_003F_FFFF_FFFC};
    vecs[5]  = '{12'h3B0, 64'h0000_0000_0000_00FF, 12'h3B0, 64'h0000_0000_0000_00FC};
    vecs[6]  = '{12'h3B1, 64'h0000_0000_0000_0043, 12'h3B1, 64'h0000_0000_0000_0040};
    vecs[7]  = '{12'h3A0, 64'h0000_0000_0000_0018, 12'h3B0, 64'h0000_0000_0000_00FF};
    vecs[8]  = '{12'h3A0, 64'h0000_0000_0000_8908, 12'h3A0, 64'h0000_0000_0000_8908};
    vecs[9]  = '{12'h3B0, 64'h0000_0000_0000_1234, 12'h3B0, 64'h0000_0000_0000_00FC};
    vecs[10] = '{12'h3B1, 64'h0000_0000_0000_5678, 12'h3B1, 64'h0000_0000_0000_0040};
    vecs[11] = '{12'h3A0, 64'h0000_0000_0000_0000, 12'h3A0, 64'h0000_0000_0000_8900};
    vecs[12] = '{12'h3A1, 64'h0000_0000_0000_FFFF, 12'h3A0, 64'h0000_0000_0000_8900};
    vecs[13] = '{12'h3A2, 64'hFFFF_FFFF_9F1F_1F1F, 12'h3A2, 64'h0000_0000_9F1F_1F1F};
    vecs[14] = '{12'h3A2, 64'h0000_0000_0000_0000, 12'h3A2, 64'h0000_0000_9F00_0000};
    vecs[15] = '{12'h3BB, 64'h0000_0000_0000_0077, 12'h3BB, 64'h0000_0000_0000_0001};
    vecs[16] = '{12'h3BC, 64'h0000_0000_0000_0077, 12'h3BC, 64'h0000_0000_0000_0000};
    vecs[17] = '{12'h3BA, 64'h0000_0000_0000_0055, 12'h3BA, 64'h0000_0000_0000_0054};
    vecs[18] = '{12'h300, 64'h0000_0000_0000_0123, 12'h300, 64'h0000_0000_0000_0000};
    vecs[19] = '{12'h3AE, 64'hFFFF_FFFF_FFFF_FFFF, 12'h3AE, 64'h0000_0000_0000_0000};
    vecs[20] = '{12'h7C0, 64'h0000_0000_0000_0000, 12'h3A3, 64'h0000_0000_0000_0000};
    vecs[21] = '{12'h3B2, 64'h0000_0000_0000_0ABF, 12'h3B2, 64'h0000_0000_0000_0ABC};

    model_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    CSRRAdr = 12'h3A0;
    #1;
    check("reset_ready", 64'(CSRWReady), 64'd1);
    check("reset_updated", 64'(PMPUpdated), 64'd0);
    check("reset_illegal", 64'(IllegalAccess), 64'd0);
    check("reset_read_cfg0", CSRRData, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_arrays("reset");

    for (int i = 0; i < 22; i++) begin
      do_write(vecs[i].wadr, vecs[i].wdata);
      CSRRAdr = vecs[i].radr;
      #1;
      check($sformatf("vec%0d_read", i), CSRRData, vecs[i].rexp);
    end
    check_arrays("after_vecs");

    for (int it = 0; it < 250; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: a = 12'h3A0 + 12'($urandom_range(0, 15));
        4, 5, 6, 7, 8: a = 12'h3B0 + 12'($urandom_range(0, 13));
        default: a = 12'h3F0 + 12'($urandom_range(0, 15));
      endcase
      do_write(a, rand_data());
      for (int r = 0; r < 3; r++) begin
        CSRRAdr = 12'h39F + 12'($urandom_range(0, 81));
        #1;
        check($sformatf("rand_read_%h", CSRRAdr), CSRRData, model_read(CSRRAdr));
      end
      if (it % 10 == 9) check_arrays("rand");
    end

    // Reset asserted while byte 3 of a cfg write is pending.
    @(negedge clk);
    CSRWAdr   = 12'h3A0;
    CSRWData  = 64'h0F0F_0F0F_0F0F_0F0F;
    CSRWValid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    CSRWValid = 1'b0;
    repeat (3) @(negedge clk);
    check("midcfg_ready_low", 64'(CSRWReady), 64'd0);
    reset_n = 1'b0;
    #1;
    model_reset();
    check("midcfg_rst_ready", 64'(CSRWReady), 64'd1);
    check("midcfg_rst_updated", 64'(PMPUpdated), 64'd0);
    check_arrays("midcfg_rst");
    @(negedge clk);
    reset_n = 1'b1;
    upd_n = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (PMPUpdated === 1'b1) upd_n++;
    end
    check("midcfg_no_updated", 64'(upd_n), 64'd0);
    check("midcfg_ready_after", 64'(CSRWReady), 64'd1);
    CSRRAdr = 12'h3A0;
    #1;
    check("midcfg_read_cfg0", CSRRData, 64'd0);

    // Second write accepted in the same cycle the first PMPUpdated pulse is driven.
    @(negedge clk);
    CSRWAdr   = 12'h3B3;
    CSRWData  = 64'h1000;
    CSRWValid = 1'b1;
    @(posedge clk);
    model_write(12'h3B3, 64'h1000);
    @(negedge clk);
    check("b2b_updated_first", 64'(PMPUpdated), 64'd1);
    check("b2b_ready_first", 64'(CSRWReady), 64'd1);
    CSRWAdr  = 12'h3B4;
    CSRWData = 64'h2000;
    @(posedge clk);
    model_write(12'h3B4, 64'h2000);
    @(negedge clk);
    CSRWValid = 1'b0;
    check("b2b_updated_second", 64'(PMPUpdated), 64'd1);
    @(negedge clk);
    check("b2b_updated_clear", 64'(PMPUpdated), 64'd0);
    CSRRAdr = 12'h3B3;
    #1;
    check("b2b_read_addr3", CSRRData, 64'h1000);
    CSRRAdr = 12'h3B4;
    #1;
    check("b2b_read_addr4", CSRRData, 64'h2000);
    check_arrays("b2b");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
